// File: rtl/out_fifo_arbiter_if.sv
// Requester-side bus of the output FIFO arbiter: per-requester request,
// byte handshake and the registered grant vector.
interface out_fifo_arbiter_if;
   logic [1:0]  req_i;
   logic [1:0]  valid_i;
   logic [15:0] data_i;
   logic [1:0]  ready_o;
   logic [1:0]  grant_o;

   // Requester side drives requests and bytes.
   modport master (
      output req_i,
      output valid_i,
      output data_i,
      input  ready_o,
      input  grant_o
   );

   // Arbiter side accepts bytes and reports ownership.
   modport slave (
      input  req_i,
      input  valid_i,
      input  data_i,
      output ready_o,
      output grant_o
   );
endinterface

// File: rtl/out_fifo_arbiter.sv
// Packet-atomic round-robin arbiter for the FPGA-to-host output FIFO write port.
// Requester 0 is the command/response controller, requester 1 the input-stream
// packetiser. A packet is a header {cmd[1:0], len[5:0]} plus len payload bytes.
// A stalled owner has its packet zero-padded to length and err_timeout_o is set.
module out_fifo_arbiter #(
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
   input  logic               clk_24576000_i,
   input  logic               reset_i,
   out_fifo_arbiter_if.slave  req_if,
   output logic               wr_out_fifo_en_o,
   output logic [7:0]         wr_out_fifo_data_o,
   input  logic               wr_out_fifo_full_i,
   input  logic               wr_out_fifo_afull_i,
   output logic               pkt_done_o,
   output logic               err_timeout_o
);

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      PAYLOAD,
      PAD,
      DONE
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic [5:0] cnt_q, cnt_d;
   logic [7:0] tmo_q, tmo_d;
   logic [7:0] tmo_inc;
   logic       last_q, last_d;
   logic       wr_en_d;
   logic [7:0] wr_data_d;
   logic       done_d;
   logic       err_d;

   logic       fifo_ok;
   logic       owner;
   logic       accepting;
   logic [1:0] ready_w;
   logic       xfer;
   logic [7:0] owner_byte;

   // Almost-full is treated as full so the registered in-flight write always has a slot.
   assign fifo_ok    = ~wr_out_fifo_full_i & ~wr_out_fifo_afull_i;
   assign owner      = grant_q[1];
   assign accepting  = ((state_q == HEADER) || (state_q == PAYLOAD)) && fifo_ok;
   assign ready_w    = accepting ? grant_q : 2'b00;
   assign xfer       = |(req_if.valid_i & ready_w);
   assign owner_byte = owner ? req_if.data_i[15:8] : req_if.data_i[7:0];
   assign tmo_inc    = (tmo_q >= TIMEOUT_CYCLES) ? tmo_q : tmo_q + 8'd1;

   assign req_if.ready_o = ready_w;
   assign req_if.grant_o = grant_q;

   // Next-state, grant, counters and write-port decisions for the current cycle.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      last_d    = last_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_out_fifo_data_o;
      done_d    = 1'b0;
      err_d     = err_timeout_o;

      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            unique case (req_if.req_i)
               2'b01: begin
                  grant_d = 2'b01;
                  state_d = HEADER;
               end
               2'b10: begin
                  grant_d = 2'b10;
                  state_d = HEADER;
               end
               2'b11: begin
                  grant_d = last_q ? 2'b01 : 2'b10;
                  state_d = HEADER;
               end
               default: state_d = IDLE;
            endcase
         end

         HEADER: begin
            if (xfer) begin
               wr_en_d   = 1'b1;
               wr_data_d = owner_byte;
               cnt_d     = owner_byte[5:0];
               tmo_d     = '0;
               state_d   = (owner_byte[5:0] == 6'd0) ? DONE : PAYLOAD;
            end else if (!req_if.req_i[owner]) begin
               grant_d = '0;
               state_d = IDLE;
            end
         end

         PAYLOAD: begin
            if (xfer) begin
               wr_en_d   = 1'b1;
               wr_data_d = owner_byte;
               tmo_d     = '0;
               if (cnt_q <= 6'd1) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 6'd1;
               end
            end else if (fifo_ok) begin
               // Only owner stalls count; FIFO backpressure freezes the idle counter.
               tmo_d = tmo_inc;
               if (tmo_inc >= TIMEOUT_CYCLES) begin
                  err_d   = 1'b1;
                  state_d = PAD;
               end
            end
         end

         PAD: begin
            if (fifo_ok) begin
               wr_en_d   = 1'b1;
               wr_data_d = '0;
               if (cnt_q <= 6'd1) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 6'd1;
               end
            end
         end

         DONE: begin
            done_d  = 1'b1;
            last_d  = owner;
            grant_d = '0;
            state_d = IDLE;
         end

         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State register plus registered write port, completion pulse and sticky error.
   always_ff @(posedge clk_24576000_i) begin
      if (reset_i) begin
         state_q            <= IDLE;
         grant_q            <= '0;
         cnt_q              <= '0;
         tmo_q              <= '0;
         last_q             <= 1'b1;
         wr_out_fifo_en_o   <= 1'b0;
         wr_out_fifo_data_o <= '0;
         pkt_done_o         <= 1'b0;
         err_timeout_o      <= 1'b0;
      end else begin
         state_q            <= state_d;
         grant_q            <= grant_d;
         cnt_q              <= cnt_d;
         tmo_q              <= tmo_d;
         last_q             <= last_d;
         wr_out_fifo_en_o   <= wr_en_d;
         wr_out_fifo_data_o <= wr_data_d;
         pkt_done_o         <= done_d;
         err_timeout_o      <= err_d;
      end
   end

endmodule
